// File: rtl/window_gen_3x3.sv
// Raster-to-window front end: turns a pixel stream into 3x3 stride-1 neighbourhoods
// using two row-deep line buffers and a column shift window.
module window_gen_3x3 #(
   parameter int IMG_W = 5,
   parameter int IMG_H = 5,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_valid,
   input  logic [DW-1:0] pix_in,
   input  logic          pix_sof,
   output logic          win_valid,
   output logic [DW-1:0] win_0,
   output logic [DW-1:0] win_1,
   output logic [DW-1:0] win_2,
   output logic [DW-1:0] win_3,
   output logic [DW-1:0] win_4,
   output logic [DW-1:0] win_5,
   output logic [DW-1:0] win_6,
   output logic [DW-1:0] win_7,
   output logic [DW-1:0] win_8,
   output logic          frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col, c_eff;
   logic [RW-1:0] row, r_eff;
   logic          last_col, last_row, emit;

   logic [DW-1:0] lb1 [IMG_W];
   logic [DW-1:0] lb2 [IMG_W];
   logic [DW-1:0] rd_a, rd_b;

   // Only the two older window columns are stored; the newest column is {rd_a, rd_b, pix_in}.
   logic [DW-1:0] h_t1, h_t2, h_m1, h_m2, h_b1, h_b2;

   always_comb begin
      c_eff    = pix_sof ? '0 : col;
      r_eff    = pix_sof ? '0 : row;
      last_col = (c_eff == CW'(IMG_W - 1));
      last_row = (r_eff == RW'(IMG_H - 1));
      rd_a     = lb2[c_eff];
      rd_b     = lb1[c_eff];
      emit     = pix_valid && (r_eff >= RW'(2)) && (c_eff >= CW'(2));
   end

   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb2[c_eff] <= rd_b;
         lb1[c_eff] <= pix_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         h_t1       <= '0;
         h_t2       <= '0;
         h_m1       <= '0;
         h_m2       <= '0;
         h_b1       <= '0;
         h_b2       <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         win_0      <= '0;
         win_1      <= '0;
         win_2      <= '0;
         win_3      <= '0;
         win_4      <= '0;
         win_5      <= '0;
         win_6      <= '0;
         win_7      <= '0;
         win_8      <= '0;
      end else if (pix_valid) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : r_eff + RW'(1);
         end else begin
            col <= c_eff + CW'(1);
            row <= r_eff;
         end
         h_t1       <= h_t2;
         h_t2       <= rd_a;
         h_m1       <= h_m2;
         h_m2       <= rd_b;
         h_b1       <= h_b2;
         h_b2       <= pix_in;
         win_valid  <= emit;
         frame_done <= emit && last_col && last_row;
         if (emit) begin
            win_0 <= h_t1;
            win_1 <= h_t2;
            win_2 <= rd_a;
            win_3 <= h_m1;
            win_4 <= h_m2;
            win_5 <= rd_b;
            win_6 <= h_b1;
            win_7 <= h_b2;
            win_8 <= pix_in;
         end
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end
   end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Raster-to-window front end that feeds conv3x3.
- Accepts one 8-bit pixel per valid cycle in row-major order (IMG_W x IMG_H frame).
- Buffers the two previous rows in line buffers and a 3x3 shift window.
- Emits each fully-inside 3x3 neighbourhood (stride 1, no padding) on win_0..win_8 with win_valid; these map directly to conv3x3 data_in_0..8 / data_in_valid.

Parameters:
- IMG_W, 5: pixels per row (>=3).
- IMG_H, 5: rows per frame (>=3).
- DW, 8: pixel width in bits.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pix_valid  input  1  pix_in is valid this cycle.
- pix_in  input  DW  pixel, raster order, unsigned.
- pix_sof  input  1  qualified by pix_valid; marks this pixel as (row 0, col 0).
- win_valid  output  1  win_0..win_8 valid, one-cycle pulse per window.
- win_0 .. win_8  output  DW each  window pixels, row-major: win_0 = (r-2,c-2), win_4 = (r-1,c-1), win_8 = (r,c).
- frame_done  output  1  pulses together with the last window of a frame.

Behaviour:
- Reset (async, rst=1): win_valid=0, frame_done=0, win_0..8=0, col/row counters=0, shift window regs=0. Line buffer RAM is not reset; stale contents are masked by the row>=2 rule.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1, width $clog2 of each dimension. Counters advance only on pix_valid.
  - col wraps to 0 at IMG_W-1 and increments row.
  - row wraps to 0 after (IMG_H-1, IMG_W-1), so back-to-back frames need no sof.
- pix_sof with pix_valid: the pixel is treated as (0,0) regardless of counter state. This resyncs mid-frame. Partial-frame windows already emitted stand; no flush occurs.
- Line buffers: two IMG_W-deep arrays, lb1 (row r-1) and lb2 (row r-2), indexed by col. On an accepted pixel at col c:
  - read a=lb2[c], b=lb1[c];
  - write lb2[c]<=b, lb1[c]<=pix_in.
  - Combinational read, registered write.
- Shift window: on each accepted pixel, the 3 columns shift left. The new right column is {a, b, pix_in} (top, mid, bottom).
- Emission: if accepted pixel has row>=2 and col>=2, then next cycle win_valid=1 and win_0..8 hold that window. Latency is exactly 1 clk from accepting the completing pixel.
  - Otherwise win_valid=0.
  - win_0..8 hold their last values when win_valid=0.
- Windows never straddle rows, because the col>=2 gate ensures all 3 columns come from the same row.
- Windows per frame = (IMG_W-2)*(IMG_H-2), 9 for 5x5.
- frame_done=1 in the same cycle as win_valid for the window completed by pixel (IMG_H-1, IMG_W-1). Otherwise frame_done=0.
- Gaps: pix_valid=0 cycles freeze all state. Throughput is 1 window/cycle with no backpressure, which matches conv3x3 (no ready).
- Simultaneous pix_sof with an expected wrap: sof wins. Result is identical (0,0).
- Reset mid-frame: outputs go to 0 immediately. The next accepted pixel is (0,0).

Test Plan:
- Ramp frame 1..25 (5x5), continuous valid:
  - first win_valid one cycle after pixel 13 accepted, window = 1,2,3,6,7,8,11,12,13;
  - 9 windows total;
  - last window = 13,14,15,18,19,20,23,24,25 with frame_done=1.
  - Chained to conv3x3 with weights 1,1,1,1,2,1,1,1,1 and bias 0, outputs are 70 (first) and 190 (last).
- Same ramp with pix_valid toggling 1,0,0,1,... -> identical 9 windows in order; each is 1 cycle after its completing pixel; win_* hold between pulses.
- Back-to-back frames (ramp, then checkerboard (i+j)%2?1:2) with no sof -> 18 windows, 2 frame_done pulses.
  - Second frame's first window is 2,1,2,1,2,1,2,1,2, with no ramp pixels leaking in.
- Assert pix_sof on pixel 8 of a frame, then stream a full 5x5 (center 3x3=10, border=1) -> 9 windows.
  - First window is 1,1,1,1,10,10,1,10,10.
  - Centre window is all 10.
- Assert rst for 2 cycles after pixel 17 of the ramp -> win_valid/frame_done/win_* read 0 during reset; a following full ramp frame yields exactly the 9 expected windows.
- IMG_W=7, IMG_H=4 ramp 1..28 -> 10 windows; first = 1,2,3,8,9,10,15,16,17; frame_done with the window ending in 28.
